lab62soc_key_event_ctrl: RTL and testbench

LAB62SOC_KEY_EVENT_CTRL -- requirements
Module: lab62soc_key_event_ctrl

---
 rtl/lab62soc_key_event_ctrl_if.sv | 27 ++
 rtl/lab62soc_key_event_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_lab62soc_key_event_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lab62soc_key_event_ctrl_if.sv
// ---------------------------------------------------------------------------
// lab62soc_key_event_ctrl_if
// Avalon-MM slave bus bundle for the key event controller.
//   address    [1:0]   word address
//   chipselect         slave select
//   read / write       strobes, qualified by chipselect
//   writedata  [31:0]  write data
//   readdata   [31:0]  registered read data (driven by the slave)
// ---------------------------------------------------------------------------
interface lab62soc_key_event_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, read, write, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read, write, writedata,
    output readdata
  );
endinterface

// File: rtl/lab62soc_key_event_ctrl.sv
// ---------------------------------------------------------------------------
// lab62soc_key_event_ctrl
// Debounces the two active-low push buttons, turns accepted level changes
// into press/release events, queues them in a small FIFO and exposes status,
// the FIFO head and an interrupt through an Avalon-MM slave.
//
// Ports
//   clk       system clock, all state on the rising edge
//   reset_n   asynchronous active-low reset
//   bus       Avalon-MM slave (address, chipselect, read, write,
//             writedata, readdata)
//   in_port   raw KEY[1:0], active-low, asynchronous to clk
//   irq       registered level interrupt, active-high
//
// Register map (word addresses)
//   0  R   {30'b0, stable[1:0]}
//   1  R   {valid, 29'b0, type, key} of the FIFO head; pops when valid
//   2  RW  read {overflow, 23'b0, count[7:0]}; write bit 31 = 1 clears overflow
//   3  RW  irq_en at bit 0
// ---------------------------------------------------------------------------
module lab62soc_key_event_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int FIFO_DEPTH      = 4       // power of two, at least 2
) (
  input  logic                            clk,
  input  logic                            reset_n,
  lab62soc_key_event_ctrl_if.slave        bus,
  input  logic [1:0]                      in_port,
  output logic                            irq
);

  localparam int CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);

  // Per-key view of the debounce/pending logic
  logic [1:0] stable_lvl;
  logic [1:0] evt_fire;
  logic [1:0] pend;
  logic [1:0] pend_type;
  logic [1:0] push_sel;

  // FIFO state
  logic [1:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [FCNT_W-1:0] count_reg, count_next;

  // Control/status registers
  logic [31:0] readdata_reg, readdata_next;
  logic        ovf_reg, ovf_next;
  logic        irq_en_reg, irq_en_next;
  logic        irq_reg, irq_next;

  logic        rd_en, wr_en;
  logic        push_req, push_ok, pop, fifo_full, ovf_set;
  logic [1:0]  push_entry;
  logic [7:0]  count_byte;

  // -------------------------------------------------------------------------
  // Per-key synchronizer, debounce counter and one-entry pending slot
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_key
      logic             sync1_reg, sync2_reg, stable_reg;
      logic [CNT_W-1:0] cnt_reg;
      logic             pend_reg, pend_type_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          sync1_reg     <= 1'b1;
          sync2_reg     <= 1'b1;
          stable_reg    <= 1'b1;
          cnt_reg       <= '0;
          pend_reg      <= 1'b0;
          pend_type_reg <= 1'b0;
        end else begin
          sync1_reg <= in_port[gi];
          sync2_reg <= sync1_reg;

          if (sync2_reg == stable_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_MAX) begin
            stable_reg <= sync2_reg;
            cnt_reg    <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end

          // A fresh event wins over the slot being drained the same cycle.
          // The old stable level is the event type: 1->0 is a press (1).
          if (evt_fire[gi]) begin
            pend_reg      <= 1'b1;
            pend_type_reg <= stable_reg;
          end else if (push_sel[gi]) begin
            pend_reg <= 1'b0;
          end
        end
      end

      assign evt_fire[gi]   = (sync2_reg != stable_reg) && (cnt_reg == CNT_MAX);
      assign stable_lvl[gi] = stable_reg;
      assign pend[gi]       = pend_reg;
      assign pend_type[gi]  = pend_type_reg;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Push arbitration: key 0 first, key 1 drains on the following cycle.
  // The key field is 1 for KEY0 and 0 for KEY1, so a KEY0 press reads back
  // as 0x80000003 and a KEY1 press as 0x80000002.
  // -------------------------------------------------------------------------
  always_comb begin
    push_sel   = 2'b00;
    push_entry = 2'b00;
    if (pend[0]) begin
      push_sel   = 2'b01;
      push_entry = {pend_type[0], 1'b1};
    end else if (pend[1]) begin
      push_sel   = 2'b10;
      push_entry = {pend_type[1], 1'b0};
    end
  end

  assign push_req  = |pend;
  assign rd_en     = bus.chipselect & bus.read;
  assign wr_en     = bus.chipselect & bus.write;
  assign fifo_full = (count_reg == FIFO_FULL);
  assign pop       = rd_en && (bus.address == 2'd1) && (count_reg != '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok   = push_req && (!fifo_full || pop);
  assign ovf_set   = push_req && fifo_full && !pop;
  assign count_byte = 8'(count_reg);

  // -------------------------------------------------------------------------
  // FIFO
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_reg] <= push_entry;
    end
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push_ok) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end
    case ({push_ok, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // -------------------------------------------------------------------------
  // Register file, read mux and interrupt
  // -------------------------------------------------------------------------
  always_comb begin
    readdata_next = readdata_reg;
    if (rd_en) begin
      case (bus.address)
        2'd0:    readdata_next = {30'b0, stable_lvl};
        2'd1:    readdata_next = (count_reg != '0) ?
                                 {1'b1, 29'b0, fifo_mem[rd_ptr_reg]} : 32'b0;
        2'd2:    readdata_next = {ovf_reg, 23'b0, count_byte};
        default: readdata_next = {31'b0, irq_en_reg};
      endcase
    end
  end

  always_comb begin
    ovf_next    = ovf_reg;
    irq_en_next = irq_en_reg;
    // A new overflow in the same cycle as a clear leaves the flag set.
    if (ovf_set) begin
      ovf_next = 1'b1;
    end else if (wr_en && (bus.address == 2'd2) && bus.writedata[31]) begin
      ovf_next = 1'b0;
    end
    if (wr_en && (bus.address == 2'd3)) begin
      irq_en_next = bus.writedata[0];
    end
    irq_next = irq_en_reg & ((count_reg != '0) | ovf_reg);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_reg <= '0;
      ovf_reg      <= 1'b0;
      irq_en_reg   <= 1'b0;
      irq_reg      <= 1'b0;
    end else begin
      readdata_reg <= readdata_next;
      ovf_reg      <= ovf_next;
      irq_en_reg   <= irq_en_next;
      irq_reg      <= irq_next;
    end
  end

  assign bus.readdata = readdata_reg;
  assign irq          = irq_reg;

  // Only bits 31 and 0 of writedata carry meaning.
  logic unused_wdata;
  assign unused_wdata = ^bus.writedata[30:1];

endmodule

// File: tb/tb_lab62soc_key_event_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lab62soc_key_event_ctrl
// Directed scenarios plus randomized key waveforms for the key event
// controller. The random part predicts events from run lengths of each key
// level: a run of a new level lasting at least DEBOUNCE_CYCLES is accepted,
// shorter runs are ignored, and events are ordered by acceptance time with
// key 0 first on ties. The queue keeps the first FIFO_DEPTH events.
// ---------------------------------------------------------------------------
module tb_lab62soc_key_event_ctrl;
  localparam int D     = 8;
  localparam int DEPTH = 4;
  localparam int T     = 100;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] in_port;
  logic       irq;

  int total = 0;
  int bad   = 0;

  lab62soc_key_event_ctrl_if bus();

  lab62soc_key_event_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus),
    .in_port(in_port),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_keys(input logic [1:0] v);
    @(negedge clk);
    in_port = v;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    d = bus.readdata;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] v);
    @(negedge clk);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.writedata  = v;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    logic [31:0] d;
    reset_n = 1'b0;
    wait_cycles(3);
    total++; if (bus.readdata !== 32'h0) begin bad++; $display("FAIL reset_readdata: got %h want %h", bus.readdata, 32'h0); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
    reset_n = 1'b1;
    wait_cycles(2);
    bus_read(2'd0, d);
    total++; if (d !== 32'h3) begin bad++; $display("FAIL reset_addr0: got %h want %h", d, 32'h3); end
    bus_read(2'd2, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_addr2: got %h want %h", d, 32'h0); end
    bus_read(2'd3, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_addr3: got %h want %h", d, 32'h0); end
    bus_read(2'd1, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_addr1: got %h want %h", d, 32'h0); end
    $display("test_reset done");
  endtask

  task automatic test_single_press();
    logic [31:0] d;
    set_keys(2'b10);
    wait_cycles(20);
    bus_read(2'd1, d);
    total++; if (d !== 32'h80000003) begin bad++; $display("FAIL s1_press: got %h want %h", d, 32'h80000003); end
    bus_read(2'd1, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL s1_empty: got %h want %h", d, 32'h0); end
    bus_read(2'd0, d);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL s1_stable: got %h want %h", d, 32'h2); end
    set_keys(2'b11);
    wait_cycles(20);
    bus_read(2'd1, d);
    total++; if (d !== 32'h80000001) begin bad++; $display("FAIL s1_release: got %h want %h", d, 32'h80000001); end
    bus_read(2'd2, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL s1_count: got %h want %h", d, 32'h0); end
    $display("test_single_press done");
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    set_keys(2'b01);
    wait_cycles(4);
    set_keys(2'b11);
    wait_cycles(20);
    bus_read(2'd0, d);
    total++; if (d !== 32'h3) begin bad++; $display("FAIL s2_stable: got %h want %h", d, 32'h3); end
    bus_read(2'd2, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL s2_count: got %h want %h", d, 32'h0); end
    // D-1 cycles low is still a glitch
    set_keys(2'b01);
    wait_cycles(D - 2);
    set_keys(2'b11);
    wait_cycles(20);
    bus_read(2'd2, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL s2_edge_count: got %h want %h", d, 32'h0); end
    $display("test_glitch done");
  endtask

  task automatic test_simultaneous();
    logic [31:0] d;
    int t1, t2;
    logic [7:0] c1;
    t1 = -1; t2 = -1; c1 = 8'h0;
    set_keys(2'b00);
    bus.address    = 2'd2;
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (t1 < 0 && bus.readdata[7:0] != 8'h0) begin t1 = i; c1 = bus.readdata[7:0]; end
      if (t2 < 0 && bus.readdata[7:0] >= 8'h2) t2 = i;
    end
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    total++; if (t1 < 0 || t2 < 0) begin bad++; $display("FAIL s3_timeout: got t1=%0d t2=%0d want both seen", t1, t2); end
    total++; if (c1 !== 8'h1) begin bad++; $display("FAIL s3_first_count: got %0d want 1", c1); end
    total++; if (t2 - t1 != 1) begin bad++; $display("FAIL s3_spacing: got %0d want 1", t2 - t1); end
    bus_read(2'd1, d);
    total++; if (d !== 32'h80000003) begin bad++; $display("FAIL s3_key0: got %h want %h", d, 32'h80000003); end
    bus_read(2'd1, d);
    total++; if (d !== 32'h80000002) begin bad++; $display("FAIL s3_key1: got %h want %h", d, 32'h80000002); end
    set_keys(2'b11);
    wait_cycles(20);
    bus_read(2'd1, d);
    total++; if (d !== 32'h80000001) begin bad++; $display("FAIL s3_rel0: got %h want %h", d, 32'h80000001); end
    bus_read(2'd1, d);
    total++; if (d !== 32'h80000000) begin bad++; $display("FAIL s3_rel1: got %h want %h", d, 32'h80000000); end
    bus_read(2'd1, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL s3_empty: got %h want %h", d, 32'h0); end
    $display("test_simultaneous done");
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic [31:0] exp_word [4];
    exp_word[0] = 32'h80000003; exp_word[1] = 32'h80000001;
    exp_word[2] = 32'h80000003; exp_word[3] = 32'h80000001;
    for (int i = 0; i < 5; i++) begin
      set_keys((i % 2 == 0) ? 2'b10 : 2'b11);
      wait_cycles(14);
    end
    wait_cycles(6);
    bus_read(2'd2, d);
    total++; if (d !== 32'h80000004) begin bad++; $display("FAIL s4_full: got %h want %h", d, 32'h80000004); end
    bus_write(2'd2, 32'h7FFFFFFF);
    bus_read(2'd2, d);
    total++; if (d !== 32'h80000004) begin bad++; $display("FAIL s4_noclear: got %h want %h", d, 32'h80000004); end
    bus_write(2'd2, 32'h80000000);
    bus_read(2'd2, d);
    total++; if (d !== 32'h00000004) begin bad++; $display("FAIL s4_clear: got %h want %h", d, 32'h00000004); end
    for (int i = 0; i < 4; i++) begin
      bus_read(2'd1, d);
      total++; if (d !== exp_word[i]) begin bad++; $display("FAIL s4_entry%0d: got %h want %h", i, d, exp_word[i]); end
    end
    set_keys(2'b11);
    wait_cycles(20);
    bus_read(2'd1, d);
    total++; if (d !== 32'h80000001) begin bad++; $display("FAIL s4_after: got %h want %h", d, 32'h80000001); end
    bus_read(2'd2, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL s4_drained: got %h want %h", d, 32'h0); end
    $display("test_overflow done");
  endtask

  task automatic test_write_ignore();
    logic [31:0] d;
    bus_read(2'd0, d);
    bus_write(2'd0, 32'h0);
    total++; if (bus.readdata !== 32'h3) begin bad++; $display("FAIL wr_readdata_hold: got %h want %h", bus.readdata, 32'h3); end
    bus_write(2'd1, 32'hFFFFFFFF);
    bus_read(2'd2, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL wr_addr1_ignored: got %h want %h", d, 32'h0); end
    bus_write(2'd3, 32'hFFFFFFFE);
    bus_read(2'd3, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL wr_irq_en_bit0: got %h want %h", d, 32'h0); end
    $display("test_write_ignore done");
  endtask

  task automatic test_irq();
    logic [31:0] d;
    logic prev_irq;
    bit found;
    found = 0;
    bus_write(2'd3, 32'hFFFFFFFF);
    bus_read(2'd3, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL s5_irq_en: got %h want %h", d, 32'h1); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL s5_irq_idle: got %b want 0", irq); end
    set_keys(2'b10);
    bus.address    = 2'd2;
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    prev_irq = irq;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus.readdata[7:0] == 8'h1) begin
        found = 1;
        total++; if (irq !== 1'b1 || prev_irq !== 1'b0) begin bad++; $display("FAIL s5_irq_rise: got irq=%b prev=%b want 1/0", irq, prev_irq); end
      end
      prev_irq = irq;
    end
    total++; if (!found) begin bad++; $display("FAIL s5_timeout: got no push want push within 40 cycles"); end
    bus.address = 2'd1;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    d = bus.readdata;
    total++; if (d !== 32'h80000003) begin bad++; $display("FAIL s5_pop: got %h want %h", d, 32'h80000003); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL s5_irq_hold: got %b want 1", irq); end
    @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL s5_irq_fall: got %b want 0", irq); end
    bus_write(2'd3, 32'h0);
    set_keys(2'b11);
    wait_cycles(20);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL s5_irq_masked: got %b want 0", irq); end
    bus_read(2'd1, d);
    total++; if (d !== 32'h80000001) begin bad++; $display("FAIL s5_release: got %h want %h", d, 32'h80000001); end
    $display("test_irq done");
  endtask

  task automatic test_reset_midflight();
    logic [31:0] d;
    bus_write(2'd3, 32'h1);
    set_keys(2'b10); wait_cycles(14);
    set_keys(2'b00); wait_cycles(14);
    set_keys(2'b01); wait_cycles(14);
    bus_read(2'd2, d);
    total++; if (d !== 32'h3) begin bad++; $display("FAIL s6_queued: got %h want %h", d, 32'h3); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL s6_irq_before: got %b want 1", irq); end
    set_keys(2'b10);
    wait_cycles(4);
    #2 reset_n = 1'b0;
    #1;
    total++; if (bus.readdata !== 32'h0) begin bad++; $display("FAIL s6_async_readdata: got %h want %h", bus.readdata, 32'h0); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL s6_async_irq: got %b want 0", irq); end
    in_port = 2'b11;
    wait_cycles(3);
    reset_n = 1'b1;
    bus_read(2'd0, d);
    total++; if (d !== 32'h3) begin bad++; $display("FAIL s6_addr0: got %h want %h", d, 32'h3); end
    bus_read(2'd1, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL s6_addr1: got %h want %h", d, 32'h0); end
    bus_read(2'd3, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL s6_addr3: got %h want %h", d, 32'h0); end
    wait_cycles(20);
    bus_read(2'd2, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL s6_no_event: got %h want %h", d, 32'h0); end
    $display("test_reset_midflight done");
  endtask

  task automatic test_random();
    bit          acc [2];
    bit          lv [2][T];
    bit          ev [2][T+D];
    bit          ev_press [2][T+D];
    logic [31:0] exp_q [$];
    logic [31:0] d, want;
    int          n, stored, bad0, t, len;
    bit          l, last;
    logic        kf;
    acc[0] = 1'b1;
    acc[1] = 1'b1;
    for (int r = 0; r < 10; r++) begin
      bad0 = bad;
      exp_q.delete();
      for (int k = 0; k < 2; k++)
        for (int j = 0; j < T + D; j++) begin ev[k][j] = 0; ev_press[k][j] = 0; end
      for (int k = 0; k < 2; k++) begin
        t = 0;
        l = ~acc[k];
        while (t < T) begin
          if ($urandom_range(9, 0) < 6) len = int'($urandom_range(D + 16, D));
          else                          len = int'($urandom_range(D - 1, 1));
          last = 0;
          if (t + len >= T) begin len = T - t; last = 1; end
          for (int j = t; j < t + len; j++) lv[k][j] = l;
          // the final run is held afterwards, so it is always long enough
          if ((last || len >= D) && l != acc[k]) begin
            ev[k][t + D - 1]       = 1;
            ev_press[k][t + D - 1] = (l == 1'b0);
            acc[k]                 = l;
          end
          t = t + len;
          l = ~l;
        end
      end
      for (int j = 0; j < T; j++) begin
        @(negedge clk);
        in_port = {lv[1][j], lv[0][j]};
      end
      wait_cycles(D + 12);
      for (int j = 0; j < T + D; j++)
        for (int k = 0; k < 2; k++)
          if (ev[k][j]) begin
            kf = (k == 0);
            exp_q.push_back({1'b1, 29'b0, ev_press[k][j], kf});
          end
      n = exp_q.size();
      stored = (n > DEPTH) ? DEPTH : n;
      want = {(n > DEPTH), 23'b0, 8'(stored)};
      bus_read(2'd2, d);
      total++; if (d !== want) begin bad++; $display("FAIL rnd%0d_status: got %h want %h", r, d, want); end
      for (int i = 0; i < stored; i++) begin
        bus_read(2'd1, d);
        total++; if (d !== exp_q[i]) begin bad++; $display("FAIL rnd%0d_entry%0d: got %h want %h", r, i, d, exp_q[i]); end
      end
      bus_read(2'd1, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL rnd%0d_empty: got %h want %h", r, d, 32'h0); end
      if (n > DEPTH) bus_write(2'd2, 32'h80000000);
      bus_read(2'd0, d);
      want = {30'b0, acc[1], acc[0]};
      total++; if (d !== want) begin bad++; $display("FAIL rnd%0d_stable: got %h want %h", r, d, want); end
      $display("random round %0d: events=%0d stored=%0d errors=%0d", r, n, stored, bad - bad0);
    end
  endtask

  initial begin
    in_port        = 2'b11;
    reset_n        = 1'b0;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.writedata  = 32'h0;
    test_reset();
    test_single_press();
    test_glitch();
    test_simultaneous();
    test_overflow();
    test_write_ignore();
    test_irq();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
